snn_seq_driver: RTL and testbench

SNN_SEQ_DRIVER -- requirements
Module: snn_seq_driver

---
 rtl/snn_seq_driver.sv | 191 +++++++++++++++++++
 tb/tb_snn_seq_driver.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_seq_driver.sv
// snn_seq_driver: sequences T_STEPS spike frames through an external spiking
// network, accumulates the per-class output spikes, and reports the class
// with the most spikes at the end of each inference run.
//
// Handshake: a frame moves on any rising clk edge where frame_valid and
// frame_ready are both high. frame_ready depends only on FSM state. The
// upstream side must hold frame_bits stable while frame_valid is high and
// frame_ready is low.
module snn_seq_driver #(
  parameter int N_IN    = 30,
  parameter int N_CLS   = 5,
  parameter int T_STEPS = 16,
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_valid,
  output logic             frame_ready,
  input  logic [N_IN-1:0]  frame_bits,
  output logic             net_start,
  output logic [N_IN-1:0]  net_spikes_in,
  input  logic             net_done,
  input  logic [N_CLS-1:0] net_spikes_out,
  output logic             result_valid,
  output logic [2:0]       result_class,
  output logic [CNT_W-1:0] result_count,
  output logic             busy,
  output logic             timeout_err,
  output logic [2:0]       dbg_state
);

  localparam int STEP_W = $clog2(T_STEPS + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(T_STEPS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    ACCUM     = 3'd4,
    GAP       = 3'd5,
    RESULT    = 3'd6
  } state_t;

  state_t              state, state_n;
  logic                armed;     // low only until the first clock after reset
  logic                done_q;    // previous net_done sample for edge detection
  logic                abort_q;   // set by a timeout: GAP returns to IDLE
  logic [N_CLS-1:0]    cap;
  logic [CNT_W-1:0]    cnt [N_CLS];
  logic [STEP_W-1:0]   step_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [2:0]          best_idx;
  logic [CNT_W-1:0]    best_val;
  logic                accept;
  logic                done_rise;
  logic                wait_expired;

  assign accept       = frame_valid & frame_ready;
  assign done_rise    = net_done & ~done_q;
  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign dbg_state    = state;

  // State register; async reset drops net_start immediately through state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_n      = state;
    frame_ready  = 1'b0;
    net_start    = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        frame_ready = armed;
        if (accept) state_n = START;
      end
      LOAD: begin
        frame_ready = armed;
        if (accept) state_n = START;
      end
      START: begin
        net_start = 1'b1;
        state_n   = WAIT_DONE;
      end
      WAIT_DONE: begin
        net_start = 1'b1;
        if (done_rise)         state_n = ACCUM;
        else if (wait_expired) state_n = GAP;
      end
      ACCUM: state_n = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (abort_q)                     state_n = IDLE;
          else if (step_cnt == STEP_LAST)  state_n = RESULT;
          else                             state_n = LOAD;
        end
      end
      RESULT: begin
        result_valid = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Winning class: strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = cnt[0];
    for (int i = 1; i < N_CLS; i++) begin
      if (cnt[i] > best_val) begin
        best_idx = 3'(i);
        best_val = cnt[i];
      end
    end
  end

  // Datapath: frame latch, done capture, counters, result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed         <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      timeout_err   <= 1'b0;
      net_spikes_in <= '0;
      cap           <= '0;
      step_cnt      <= '0;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      result_class  <= '0;
      result_count  <= '0;
      for (int i = 0; i < N_CLS; i++) cnt[i] <= '0;
    end else begin
      armed       <= 1'b1;
      done_q      <= net_done;
      timeout_err <= 1'b0;
      if (accept) net_spikes_in <= frame_bits;
      case (state)
        IDLE:  abort_q <= 1'b0;
        START: wait_cnt <= '0;
        WAIT_DONE: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (done_rise) begin
            cap <= net_spikes_out;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            abort_q     <= 1'b1;
            gap_cnt     <= GAP_W'(1);
            step_cnt    <= '0;
            for (int i = 0; i < N_CLS; i++) cnt[i] <= '0;
          end
        end
        ACCUM: begin
          // ACCUM is the first of the GAP_CYC start-low cycles.
          gap_cnt  <= GAP_W'(1);
          step_cnt <= step_cnt + 1'b1;
          for (int i = 0; i < N_CLS; i++) begin
            if (cap[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (state_n == RESULT) begin
            result_class <= best_idx;
            result_count <= best_val;
          end
        end
        RESULT: begin
          step_cnt <= '0;
          for (int i = 0; i < N_CLS; i++) cnt[i] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_seq_driver.sv
// Testbench for snn_seq_driver. Two instances: dut_a (T_STEPS=4, CNT_W=8)
// and dut_b (T_STEPS=5, CNT_W=2, for saturation). The unused one is held in
// reset; sel routes the observed outputs.
module tb_snn_seq_driver;

  localparam int GAP_CYC   = 3;
  localparam int TIMEOUT_A = 1023;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic        frame_valid;
  logic [29:0] frame_bits;
  logic        net_done;
  logic [4:0]  net_spikes_out;

  logic        a_frame_ready, a_net_start, a_result_valid, a_busy, a_timeout_err;
  logic [29:0] a_net_spikes_in;
  logic [2:0]  a_result_class, a_dbg;
  logic [7:0]  a_result_count;
  logic        b_frame_ready, b_net_start, b_result_valid, b_busy, b_timeout_err;
  logic [29:0] b_net_spikes_in;
  logic [2:0]  b_result_class, b_dbg;
  logic [1:0]  b_result_count;

  logic        m_frame_ready, m_net_start, m_result_valid, m_busy, m_timeout_err;
  logic [29:0] m_net_spikes_in;
  logic [2:0]  m_result_class;
  logic [7:0]  m_result_count;

  assign m_frame_ready   = sel ? b_frame_ready   : a_frame_ready;
  assign m_net_start     = sel ? b_net_start     : a_net_start;
  assign m_result_valid  = sel ? b_result_valid  : a_result_valid;
  assign m_busy          = sel ? b_busy          : a_busy;
  assign m_timeout_err   = sel ? b_timeout_err   : a_timeout_err;
  assign m_net_spikes_in = sel ? b_net_spikes_in : a_net_spikes_in;
  assign m_result_class  = sel ? b_result_class  : a_result_class;
  assign m_result_count  = sel ? {6'b0, b_result_count} : a_result_count;

  snn_seq_driver #(.T_STEPS(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_a), .frame_valid(frame_valid), .frame_ready(a_frame_ready),
    .frame_bits(frame_bits), .net_start(a_net_start), .net_spikes_in(a_net_spikes_in),
    .net_done(net_done), .net_spikes_out(net_spikes_out), .result_valid(a_result_valid),
    .result_class(a_result_class), .result_count(a_result_count), .busy(a_busy),
    .timeout_err(a_timeout_err), .dbg_state(a_dbg)
  );

  snn_seq_driver #(.T_STEPS(5), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .frame_valid(frame_valid), .frame_ready(b_frame_ready),
    .frame_bits(frame_bits), .net_start(b_net_start), .net_spikes_in(b_net_spikes_in),
    .net_done(net_done), .net_spikes_out(net_spikes_out), .result_valid(b_result_valid),
    .result_class(b_result_class), .result_count(b_result_count), .busy(b_busy),
    .timeout_err(b_timeout_err), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];   // {class, count} per pending inference

  // Reference: count spikes per class with saturation, pick the first maximum.
  function automatic void model(input int t, input int w, input logic [4:0] pats [0:15],
                                output int cls, output int cntv);
    int c[5];
    int mx;
    mx = (1 << w) - 1;
    for (int i = 0; i < 5; i++) c[i] = 0;
    for (int s = 0; s < t; s++)
      for (int i = 0; i < 5; i++)
        if (pats[s][i] && c[i] < mx) c[i] = c[i] + 1;
    cls = 0;
    cntv = c[0];
    for (int i = 1; i < 5; i++)
      if (c[i] > cntv) begin cls = i; cntv = c[i]; end
  endfunction

  // ---------------- driver tasks ----------------
  // One network step: hand over a frame, act as the network (done after dly
  // cycles), then follow the start-low gap until frame_ready returns.
  task automatic do_step(input logic [29:0] bits, input logic [4:0] pat, input int dly,
                         input bit lvl, input bit hold,
                         output int lows, output int rv_n,
                         output logic [2:0] rv_cls, output logic [7:0] rv_cnt);
    int n;
    lows = 0; rv_n = 0; rv_cls = '0; rv_cnt = '0;
    if (lvl) begin net_done = 1'b1; net_spikes_out = ~pat; end
    frame_valid = 1'b1;
    frame_bits  = bits;
    n = 0;
    while (m_frame_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL accept_wait: frame_ready=%b after 50 cycles, expected 1", m_frame_ready);
      frame_valid = 1'b0; net_done = 1'b0;
      return;
    end
    @(negedge clk);
    frame_valid = 1'b0;
    frame_bits  = ~bits;
    checks++;
    if (m_net_start !== 1'b1 || m_net_spikes_in !== bits) begin
      errors++;
      $display("FAIL start_latch: net_start=%b spikes_in=%h, expected 1 / %h",
               m_net_start, m_net_spikes_in, bits);
    end
    for (int k = 0; k < dly; k++) begin
      if (hold) begin frame_valid = 1'b1; frame_bits = ~bits; end
      @(negedge clk);
      checks++;
      if (m_net_start !== 1'b1 || m_net_spikes_in !== bits || m_frame_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold: start=%b spikes_in=%h ready=%b, expected 1 / %h / 0",
                 m_net_start, m_net_spikes_in, m_frame_ready, bits);
      end
    end
    frame_valid = 1'b0;
    if (lvl) begin
      net_done = 1'b0;
      @(negedge clk);
      checks++;
      if (m_net_start !== 1'b1) begin
        errors++;
        $display("FAIL level_ignore: net_start=%b after stale done, expected 1", m_net_start);
      end
    end
    net_done = 1'b1;
    net_spikes_out = pat;
    @(negedge clk);
    net_done = 1'b0;
    net_spikes_out = ~pat;
    while (m_frame_ready !== 1'b1 && lows < 20) begin
      checks++;
      if (m_net_start !== 1'b0) begin
        errors++;
        $display("FAIL gap_start: net_start=%b in gap cycle %0d, expected 0", m_net_start, lows);
      end
      if (m_result_valid === 1'b1) begin
        rv_n++; rv_cls = m_result_class; rv_cnt = m_result_count;
      end
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic run_inference(input int t, input int w, input logic [4:0] pats [0:15],
                               input int dly_lo, input int dly_hi,
                               input int lvl_step, input int hold_step, input string tag);
    int lows, rv_n, total_rv, ecls, ecnt;
    logic [2:0]  rc;
    logic [7:0]  rcnt;
    logic [10:0] got, exp_item;
    got = '1;
    total_rv = 0;
    model(t, w, pats, ecls, ecnt);
    exp_q.push_back({3'(ecls), 8'(ecnt)});
    for (int s = 0; s < t; s++) begin
      do_step(30'($urandom), pats[s], $urandom_range(dly_hi, dly_lo),
              s == lvl_step, s == hold_step, lows, rv_n, rc, rcnt);
      checks++;
      if (lows != ((s == t - 1) ? GAP_CYC + 1 : GAP_CYC)) begin
        errors++;
        $display("FAIL %s gap_len step %0d: %0d low cycles before ready, expected %0d",
                 tag, s, lows, (s == t - 1) ? GAP_CYC + 1 : GAP_CYC);
      end
      total_rv += rv_n;
      if (rv_n > 0) got = {rc, rcnt};
    end
    exp_item = exp_q.pop_front();
    checks++;
    if (total_rv != 1) begin
      errors++;
      $display("FAIL %s result_pulse: %0d result_valid cycles, expected 1", tag, total_rv);
    end
    checks++;
    if (got !== exp_item) begin
      errors++;
      $display("FAIL %s result_value: class=%0d count=%0d, expected class=%0d count=%0d",
               tag, got[10:8], got[7:0], exp_item[10:8], exp_item[7:0]);
    end
    checks++;
    if (m_result_valid !== 1'b0 || m_busy !== 1'b0 ||
        {m_result_class, m_result_count} !== exp_item) begin
      errors++;
      $display("FAIL %s result_hold: valid=%b busy=%b class=%0d count=%0d, expected 0/0/%0d/%0d",
               tag, m_result_valid, m_busy, m_result_class, m_result_count,
               exp_item[10:8], exp_item[7:0]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
    frame_valid = 1'b0; frame_bits = '0; net_done = 1'b0; net_spikes_out = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_net_start, a_frame_ready, a_result_valid, a_busy, a_timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: start/ready/valid/busy/terr=%b, expected 00000",
               {a_net_start, a_frame_ready, a_result_valid, a_busy, a_timeout_err});
    end
    checks++;
    if (a_net_spikes_in !== 30'd0 || a_result_class !== 3'd0 || a_result_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: spikes_in=%h class=%0d count=%0d, expected 0",
               a_net_spikes_in, a_result_class, a_result_count);
    end
    rst_a = 1'b1;
    #1;
    checks++;
    if (a_frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: frame_ready=%b before first clock, expected 0", a_frame_ready);
    end
    @(negedge clk);
    checks++;
    if (a_frame_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: frame_ready=%b busy=%b after first clock, expected 1/0",
               a_frame_ready, a_busy);
    end
  endtask

  task automatic test_single_class();
    logic [4:0] p [0:15];
    for (int i = 0; i < 16; i++) p[i] = 5'b00100;
    run_inference(4, 8, p, 6, 6, -1, -1, "single_class");
  endtask

  task automatic test_majority();
    logic [4:0] p [0:15];
    for (int i = 0; i < 16; i++) p[i] = '0;
    p[0] = 5'b00011; p[1] = 5'b00010; p[2] = 5'b00001; p[3] = 5'b00010;
    run_inference(4, 8, p, 1, 5, -1, -1, "majority");
  endtask

  task automatic test_tie();
    logic [4:0] p [0:15];
    for (int i = 0; i < 16; i++) p[i] = '0;
    p[0] = 5'b00011; p[1] = 5'b00011;
    run_inference(4, 8, p, 1, 5, -1, -1, "tie");
  endtask

  task automatic test_all_zero();
    logic [4:0] p [0:15];
    for (int i = 0; i < 16; i++) p[i] = '0;
    run_inference(4, 8, p, 1, 4, -1, -1, "all_zero");
  endtask

  task automatic test_level_and_hold();
    logic [4:0] p [0:15];
    for (int i = 0; i < 16; i++) p[i] = 5'($urandom);
    run_inference(4, 8, p, 2, 6, 1, 2, "level_hold");
  endtask

  task automatic test_random(input int t, input int w, input int runs);
    logic [4:0] p [0:15];
    for (int r = 0; r < runs; r++) begin
      for (int i = 0; i < 16; i++) p[i] = 5'($urandom);
      run_inference(t, w, p, 1, 8, -1, -1, "random");
    end
  endtask

  task automatic test_timeout();
    int lows, rv_n, n, rvs;
    logic [2:0] rc;
    logic [7:0] rcnt;
    logic [4:0] p [0:15];
    do_step(30'($urandom), 5'b00010, 3, 1'b0, 1'b0, lows, rv_n, rc, rcnt);
    checks++;
    if (lows != GAP_CYC) begin
      errors++;
      $display("FAIL timeout_pre_gap: %0d low cycles, expected %0d", lows, GAP_CYC);
    end
    frame_valid = 1'b1;
    frame_bits  = 30'($urandom);
    n = 0;
    while (m_frame_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    frame_valid = 1'b0;
    n = 0; rvs = 0;
    while (m_net_start === 1'b1 && n < 2000) begin
      if (m_timeout_err === 1'b1 || m_result_valid === 1'b1) rvs++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TIMEOUT_A + 1 || rvs != 0) begin
      errors++;
      $display("FAIL timeout_len: net_start high %0d cycles (early flags %0d), expected %0d (0)",
               n, rvs, TIMEOUT_A + 1);
    end
    checks++;
    if (m_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: timeout_err=%b when start dropped, expected 1", m_timeout_err);
    end
    @(negedge clk);
    checks++;
    if (m_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: timeout_err=%b one cycle later, expected 0", m_timeout_err);
    end
    n = 0; rvs = 0;
    while (m_frame_ready !== 1'b1 && n < 20) begin
      if (m_result_valid === 1'b1) rvs++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (m_frame_ready !== 1'b1 || m_busy !== 1'b0 || rvs != 0) begin
      errors++;
      $display("FAIL timeout_idle: ready=%b busy=%b result pulses=%0d, expected 1/0/0",
               m_frame_ready, m_busy, rvs);
    end
    for (int i = 0; i < 16; i++) p[i] = '0;
    p[0] = 5'b00011; p[1] = 5'b00010; p[2] = 5'b00001; p[3] = 5'b00010;
    run_inference(4, 8, p, 1, 5, -1, -1, "after_timeout");
  endtask

  task automatic test_saturate();
    logic [4:0] p [0:15];
    rst_a = 1'b0;
    sel   = 1'b1;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) p[i] = 5'b01000;
    run_inference(5, 2, p, 1, 4, -1, -1, "saturate");
  endtask

  task automatic test_reset_mid_run();
    int lows, rv_n, n;
    logic [2:0] rc;
    logic [7:0] rcnt;
    logic [4:0] p [0:15];
    do_step(30'($urandom), 5'b01000, 2, 1'b0, 1'b0, lows, rv_n, rc, rcnt);
    frame_valid = 1'b1;
    frame_bits  = 30'($urandom);
    n = 0;
    while (m_frame_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    frame_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({m_net_start, m_frame_ready, m_result_valid, m_busy, m_timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL midrun_reset_ctrl: start/ready/valid/busy/terr=%b, expected 00000",
               {m_net_start, m_frame_ready, m_result_valid, m_busy, m_timeout_err});
    end
    checks++;
    if (m_net_spikes_in !== 30'd0 || m_result_class !== 3'd0 || m_result_count !== 8'd0) begin
      errors++;
      $display("FAIL midrun_reset_data: spikes_in=%h class=%0d count=%0d, expected 0",
               m_net_spikes_in, m_result_class, m_result_count);
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (m_frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_ready: frame_ready=%b after release, expected 1", m_frame_ready);
    end
    for (int i = 0; i < 16; i++) p[i] = 5'($urandom);
    run_inference(5, 2, p, 1, 6, -1, -1, "after_reset");
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_single_class();
    test_majority();
    test_tie();
    test_all_zero();
    test_level_and_hold();
    test_random(4, 8, 5);
    test_timeout();
    test_saturate();
    test_reset_mid_run();
    test_random(5, 2, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
